// File: rtl/noisy_tone_source.sv
// Square-wave audio test tone with optional LFSR noise, streamed over valid/ready.
// Each accepted sample advances the tone phase and steps the noise LFSR once;
// a stalled sample is held untouched until the consumer takes it.
module noisy_tone_source #(
  parameter int unsigned HALF_PERIOD = 48,
  parameter int unsigned AMPLITUDE   = 1048576,
  parameter int unsigned NOISE_SHIFT = 4,
  parameter logic [23:0] LFSR_SEED   = 24'hACE001
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        enable,
  input  logic        noise_en,
  input  logic        ready,
  output logic        valid,
  output logic [23:0] sample
);

  localparam int unsigned SAMPLE_W = 24;
  localparam int unsigned SUM_W    = SAMPLE_W + 1;
  localparam int unsigned PHASE_W  = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;

  localparam logic [PHASE_W-1:0]  PHASE_LAST = PHASE_W'(HALF_PERIOD - 1);
  localparam logic [SAMPLE_W-1:0] SEED       = (LFSR_SEED == '0) ? 24'h000001 : LFSR_SEED;
  localparam logic [SAMPLE_W-1:0] SAT_POS    = 24'h7FFFFF;
  localparam logic [SAMPLE_W-1:0] SAT_NEG    = 24'h800000;

  localparam logic signed [SUM_W-1:0] TONE_POS = SUM_W'(AMPLITUDE);
  localparam logic signed [SUM_W-1:0] TONE_NEG = -TONE_POS;

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } state_t;

  state_t               state;
  state_t               state_next;
  logic                 valid_next;
  logic [SAMPLE_W-1:0]  sample_next;
  logic [PHASE_W-1:0]   phase;
  logic [PHASE_W-1:0]   phase_next;
  logic                 polarity;
  logic                 polarity_next;
  logic [SAMPLE_W-1:0]  lfsr;
  logic [SAMPLE_W-1:0]  lfsr_next;

  logic [PHASE_W-1:0]   adv_phase;
  logic                 adv_polarity;
  logic [SAMPLE_W-1:0]  adv_lfsr;

  // Fibonacci LFSR x^24+x^23+x^22+x^17+1, shifting towards the MSB.
  function automatic logic [SAMPLE_W-1:0] lfsr_step(input logic [SAMPLE_W-1:0] v);
    return {v[22:0], v[23] ^ v[22] ^ v[21] ^ v[16]};
  endfunction

  // Tone plus scaled noise, summed with one guard bit and clamped to 24-bit range.
  function automatic logic [SAMPLE_W-1:0] compose(input logic                pos,
                                                  input logic [SAMPLE_W-1:0] lf,
                                                  input logic                add_noise);
    logic signed [SUM_W-1:0] tone;
    logic signed [SUM_W-1:0] noise;
    logic signed [SUM_W-1:0] sum;
    tone  = pos ? TONE_POS : TONE_NEG;
    noise = '0;
    if (add_noise) begin
      noise = {lf[SAMPLE_W-1], lf};
      noise = noise >>> NOISE_SHIFT;
    end
    sum = tone + noise;
    if (sum[SUM_W-1] != sum[SUM_W-2]) begin
      return sum[SUM_W-1] ? SAT_NEG : SAT_POS;
    end
    return sum[SAMPLE_W-1:0];
  endfunction

  // Position, polarity and noise state that the next accepted sample would move to.
  always_comb begin
    adv_phase    = phase + PHASE_W'(1);
    adv_polarity = polarity;
    if (phase == PHASE_LAST) begin
      adv_phase    = '0;
      adv_polarity = ~polarity;
    end
    adv_lfsr = lfsr_step(lfsr);
  end

  // Next-state and next-output logic; every output is loaded into a register.
  always_comb begin
    state_next    = state;
    valid_next    = valid;
    sample_next   = sample;
    phase_next    = phase;
    polarity_next = polarity;
    lfsr_next     = lfsr;

    case (state)
      IDLE: begin
        valid_next = 1'b0;
        if (enable) begin
          sample_next = compose(1'b1, lfsr, noise_en);
          valid_next  = 1'b1;
          state_next  = STREAM;
        end
      end

      STREAM: begin
        // Without a transfer everything is frozen, including the enable decision.
        if (valid && ready) begin
          lfsr_next = adv_lfsr;
          if (enable) begin
            phase_next    = adv_phase;
            polarity_next = adv_polarity;
            sample_next   = compose(adv_polarity, adv_lfsr, noise_en);
          end else begin
            valid_next    = 1'b0;
            phase_next    = '0;
            polarity_next = 1'b1;
            state_next    = IDLE;
          end
        end
      end

      default: begin
        valid_next    = 1'b0;
        phase_next    = '0;
        polarity_next = 1'b1;
        state_next    = IDLE;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      valid    <= 1'b0;
      sample   <= '0;
      phase    <= '0;
      polarity <= 1'b1;
      lfsr     <= SEED;
    end else begin
      state    <= state_next;
      valid    <= valid_next;
      sample   <= sample_next;
      phase    <= phase_next;
      polarity <= polarity_next;
      lfsr     <= lfsr_next;
    end
  end

endmodule

// File: tb/tb_noisy_tone_source.sv
// Bench for noisy_tone_source: four configurations share one stimulus stream,
// a reference model queues each loaded sample and a negedge monitor checks it.
module tb_noisy_tone_source;

  localparam int NDUT = 4;
  localparam int HP   = 4;
  localparam int          AMP  [NDUT] = '{1000, 0, 0, 8388607};
  localparam int          NSH  [NDUT] = '{0, 0, 1, 0};
  localparam logic [23:0] SEED [NDUT] = '{24'hACE001, 24'h000001, 24'h000001, 24'h000100};

  logic        clk;
  logic        reset_n;
  logic        enable;
  logic        noise_en;
  logic        ready;
  logic        valid_v  [NDUT];
  logic [23:0] sample_v [NDUT];

  int errors = 0;
  int checks = 0;

  // Model state, one set per configuration.
  logic        m_valid [NDUT];
  logic        m_pos   [NDUT];
  int          m_cnt   [NDUT];
  logic [23:0] m_lfsr  [NDUT];
  logic [23:0] sbq     [NDUT][$];

  typedef struct {
    logic        en;
    logic        rdy;
    logic        nen;
    logic        exp_valid;
    logic [23:0] exp_sample;
  } vec_t;

  vec_t        tv  [18];
  logic [23:0] rec [10];

  noisy_tone_source #(.HALF_PERIOD(HP), .AMPLITUDE(1000), .NOISE_SHIFT(0), .LFSR_SEED(24'hACE001))
    u_tone (.clk(clk), .reset_n(reset_n), .enable(enable), .noise_en(noise_en), .ready(ready),
            .valid(valid_v[0]), .sample(sample_v[0]));
  noisy_tone_source #(.HALF_PERIOD(HP), .AMPLITUDE(0), .NOISE_SHIFT(0), .LFSR_SEED(24'h000001))
    u_noise0 (.clk(clk), .reset_n(reset_n), .enable(enable), .noise_en(noise_en), .ready(ready),
              .valid(valid_v[1]), .sample(sample_v[1]));
  noisy_tone_source #(.HALF_PERIOD(HP), .AMPLITUDE(0), .NOISE_SHIFT(1), .LFSR_SEED(24'h000001))
    u_noise1 (.clk(clk), .reset_n(reset_n), .enable(enable), .noise_en(noise_en), .ready(ready),
              .valid(valid_v[2]), .sample(sample_v[2]));
  noisy_tone_source #(.HALF_PERIOD(HP), .AMPLITUDE(8388607), .NOISE_SHIFT(0), .LFSR_SEED(24'h000100))
    u_sat (.clk(clk), .reset_n(reset_n), .enable(enable), .noise_en(noise_en), .ready(ready),
           .valid(valid_v[3]), .sample(sample_v[3]));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [23:0] act, input logic [23:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic [23:0] lfsr_adv(input logic [23:0] v);
    return {v[22:0], v[23] ^ v[22] ^ v[21] ^ v[16]};
  endfunction

  // Integer reference: +/-amplitude plus sign-extended shifted noise, clamped.
  function automatic logic [23:0] expect_sample(input int i, input logic pos,
                                                input logic [23:0] lf, input logic nen);
    int                 tone;
    int                 nz;
    int                 s;
    logic signed [31:0] wide;
    tone = pos ? AMP[i] : -AMP[i];
    nz   = 0;
    if (nen) begin
      wide = {{8{lf[23]}}, lf};
      nz   = int'(wide >>> NSH[i]);
    end
    s = tone + nz;
    if (s > 8388607)  s = 8388607;
    if (s < -8388608) s = -8388608;
    return 24'(s);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NDUT; i++) begin
      m_valid[i] = 1'b0;
      m_pos[i]   = 1'b1;
      m_cnt[i]   = 0;
      m_lfsr[i]  = SEED[i];
      sbq[i].delete();
    end
  endtask

  task automatic model_step(input int i);
    logic [23:0] dropped;
    if (!m_valid[i]) begin
      if (enable) begin
        sbq[i].push_back(expect_sample(i, 1'b1, m_lfsr[i], noise_en));
        m_valid[i] = 1'b1;
      end
    end else if (ready) begin
      if (sbq[i].size() > 0) dropped = sbq[i].pop_front();
      m_lfsr[i] = lfsr_adv(m_lfsr[i]);
      m_cnt[i]++;
      if (m_cnt[i] == HP) begin
        m_cnt[i] = 0;
        m_pos[i] = ~m_pos[i];
      end
      if (enable) begin
        sbq[i].push_back(expect_sample(i, m_pos[i], m_lfsr[i], noise_en));
      end else begin
        m_valid[i] = 1'b0;
        m_cnt[i]   = 0;
        m_pos[i]   = 1'b1;
      end
    end
  endtask

  // Reference model follows the same clock edges and asynchronous reset.
  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge reset_n);
      if (!reset_n) model_reset();
      else for (int i = 0; i < NDUT; i++) model_step(i);
    end
  end

  // Scoreboard monitor: compare each configuration against the head of its queue.
  initial begin
    forever begin
      @(negedge clk);
      if (reset_n) begin
        for (int i = 0; i < NDUT; i++) begin
          chk($sformatf("sb_valid[%0d]", i), 24'(valid_v[i]), 24'(m_valid[i]));
          if (m_valid[i]) begin
            if (sbq[i].size() == 0) begin
              checks++;
              errors++;
              $display("FAIL sb_empty[%0d]: got %h, expected a queued sample", i, sample_v[i]);
            end else begin
              chk($sformatf("sb_sample[%0d]", i), sample_v[i], sbq[i][0]);
            end
          end
        end
      end
    end
  end

  task automatic step(input logic en, input logic rdy, input logic nen);
    enable   = en;
    ready    = rdy;
    noise_en = nen;
    @(negedge clk);
  endtask

  task automatic apply_reset();
    reset_n  = 1'b0;
    enable   = 1'b0;
    ready    = 1'b0;
    noise_en = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  function automatic vec_t mk(input logic en, input logic rdy, input logic nen,
                              input logic ev, input logic [23:0] es);
    vec_t v;
    v.en = en; v.rdy = rdy; v.nen = nen; v.exp_valid = ev; v.exp_sample = es;
    return v;
  endfunction

  initial begin
    logic [23:0] p;
    logic [23:0] m;
    p = 24'd1000;
    m = -p;

    // Cycle-by-cycle expectations for the 1000-amplitude tone, incl. a 3-cycle stall.
    tv[0]  = mk(1'b0, 1'b1, 1'b0, 1'b0, 24'd0);
    tv[1]  = mk(1'b1, 1'b1, 1'b0, 1'b1, p);
    tv[2]  = mk(1'b1, 1'b1, 1'b0, 1'b1, p);
    tv[3]  = mk(1'b1, 1'b1, 1'b0, 1'b1, p);
    tv[4]  = mk(1'b1, 1'b1, 1'b0, 1'b1, p);
    tv[5]  = mk(1'b1, 1'b1, 1'b0, 1'b1, m);
    tv[6]  = mk(1'b1, 1'b1, 1'b0, 1'b1, m);
    tv[7]  = mk(1'b1, 1'b1, 1'b0, 1'b1, m);
    tv[8]  = mk(1'b1, 1'b1, 1'b0, 1'b1, m);
    tv[9]  = mk(1'b1, 1'b1, 1'b0, 1'b1, p);
    tv[10] = mk(1'b1, 1'b1, 1'b0, 1'b1, p);
    tv[11] = mk(1'b1, 1'b0, 1'b0, 1'b1, p);
    tv[12] = mk(1'b1, 1'b0, 1'b0, 1'b1, p);
    tv[13] = mk(1'b1, 1'b0, 1'b0, 1'b1, p);
    tv[14] = mk(1'b1, 1'b1, 1'b0, 1'b1, p);
    tv[15] = mk(1'b1, 1'b1, 1'b0, 1'b1, p);
    tv[16] = mk(1'b1, 1'b1, 1'b0, 1'b1, m);
    tv[17] = mk(1'b1, 1'b1, 1'b0, 1'b1, m);

    enable   = 1'b0;
    ready    = 1'b0;
    noise_en = 1'b0;
    reset_n  = 1'b1;
    #1 reset_n = 1'b0;
    #1;
    for (int i = 0; i < NDUT; i++) begin
      chk($sformatf("reset_valid[%0d]", i), 24'(valid_v[i]), 24'd0);
      chk($sformatf("reset_sample[%0d]", i), sample_v[i], 24'd0);
    end

    // Tone sequence with backpressure in the middle of a half period.
    apply_reset();
    for (int r = 0; r < 18; r++) begin
      step(tv[r].en, tv[r].rdy, tv[r].nen);
      chk($sformatf("tone_valid[%0d]", r), 24'(valid_v[0]), 24'(tv[r].exp_valid));
      chk($sformatf("tone_sample[%0d]", r), sample_v[0], tv[r].exp_sample);
    end

    // Noise determinism, plus a stall that must neither skip nor repeat a value.
    apply_reset();
    for (int k = 0; k < 5; k++) begin
      step(1'b1, 1'b1, 1'b1);
      chk($sformatf("noise0[%0d]", k), sample_v[1], 24'(1 << k));
      chk($sformatf("noise1[%0d]", k), sample_v[2], (k == 0) ? 24'd0 : 24'(1 << (k - 1)));
      if (k == 0) chk("sat_noise_first", sample_v[3], 24'h7FFFFF);
    end
    for (int k = 0; k < 3; k++) begin
      step(1'b1, 1'b0, 1'b1);
      chk($sformatf("stall_hold[%0d]", k), sample_v[1], 24'd16);
      chk($sformatf("stall_valid[%0d]", k), 24'(valid_v[1]), 24'd1);
    end
    step(1'b1, 1'b1, 1'b1);
    chk("stall_resume0", sample_v[1], 24'd32);
    step(1'b1, 1'b1, 1'b1);
    chk("stall_resume1", sample_v[1], 24'd64);
    chk("stall_resume_shift1", sample_v[2], 24'd32);

    // Full-scale tone without noise: exact positive peak, then the negated peak.
    apply_reset();
    for (int k = 0; k < 5; k++) begin
      step(1'b1, 1'b1, 1'b0);
      if (k == 0) chk("sat_first", sample_v[3], 24'h7FFFFF);
      if (k == 4) chk("sat_neg_half", sample_v[3], 24'h800001);
    end

    // Enable dropped while a sample is pending: held until taken, then idle.
    apply_reset();
    for (int k = 0; k < 6; k++) step(1'b1, 1'b1, 1'b0);
    chk("drop_pre", sample_v[0], m);
    step(1'b1, 1'b0, 1'b0);
    chk("drop_stall", sample_v[0], m);
    for (int k = 0; k < 2; k++) begin
      step(1'b0, 1'b0, 1'b0);
      chk($sformatf("drop_hold_sample[%0d]", k), sample_v[0], m);
      chk($sformatf("drop_hold_valid[%0d]", k), 24'(valid_v[0]), 24'd1);
    end
    step(1'b0, 1'b1, 1'b0);
    chk("drop_after_xfer_valid", 24'(valid_v[0]), 24'd0);
    step(1'b0, 1'b1, 1'b0);
    chk("drop_idle_valid", 24'(valid_v[0]), 24'd0);
    step(1'b1, 1'b1, 1'b0);
    chk("reenable_valid", 24'(valid_v[0]), 24'd1);
    chk("reenable_first", sample_v[0], p);

    // Asynchronous reset mid-stream, then an identical rerun.
    apply_reset();
    for (int k = 0; k < 10; k++) begin
      step(1'b1, 1'b1, 1'b1);
      rec[k] = sample_v[0];
    end
    #2 reset_n = 1'b0;
    #1;
    for (int i = 0; i < NDUT; i++) begin
      chk($sformatf("async_valid[%0d]", i), 24'(valid_v[i]), 24'd0);
      chk($sformatf("async_sample[%0d]", i), sample_v[i], 24'd0);
    end
    apply_reset();
    for (int k = 0; k < 10; k++) begin
      step(1'b1, 1'b1, 1'b1);
      chk($sformatf("rerun[%0d]", k), sample_v[0], rec[k]);
    end

    step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
